load_store_unit: RTL and testbench

Multi-cycle data-memory access sequencer sitting between the MEM stage and the data memory port. It accepts one load/store per request using the byte-enable and signedness encoding produced by instruction decode. It aligns store data and byte lanes, splits accesses that straddle a word boundary into two word transfers, and runs a req/ack handshake with a variable-latency memory. It stalls the pipeline until the access completes and returns sign- or zero-extended load data.

---
 rtl/load_store_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer: aligns lanes, splits word-straddling accesses into two transfers, extends load data.
// Zero-wait latency is 2 cycles aligned and 3 cycles split; stall_o holds the pipeline while memory withholds ack.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_wr_en_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic        req_signed_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    off_q, off_d;
  logic [3:0]    be_q, be_d;
  logic [7:0]    be8_q, be8_d;
  logic [63:0]   wd64_q, wd64_d;
  logic          wr_q, wr_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          err_q, err_d;

  logic          legal;
  logic          timed_out;
  logic [7:0]    be8_n;
  logic [63:0]   wd64_n;

  // Shift the right-aligned word into place, keep the accessed width, then extend.
  function automatic logic [31:0] load_result(input logic [63:0] dw, input logic [1:0] off,
                                              input logic [3:0] be, input logic sgn);
    logic [31:0] r;
    r = 32'(dw >> {off, 3'b000});
    if (be == 4'b0001) begin
      r = {{24{sgn & r[7]}}, r[7:0]};
    end else if (be == 4'b0011) begin
      r = {{16{sgn & r[15]}}, r[15:0]};
    end
    return r;
  endfunction

  assign legal     = (req_byte_en_i == 4'b0001) || (req_byte_en_i == 4'b0011) ||
                     (req_byte_en_i == 4'b1111);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO);
  assign be8_n     = {4'b0000, req_byte_en_i} << req_addr_i[1:0];
  assign wd64_n    = {32'h0, req_wdata_i} << {req_addr_i[1:0], 3'b000};

  assign stall_o = (state_q == S_ACC0) || (state_q == S_ACC1) ||
                   ((state_q == S_IDLE) && req_valid_i && legal);

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    be_d         = be_q;
    be8_d        = be8_q;
    wd64_d       = wd64_q;
    wr_d         = wr_q;
    sgn_d        = sgn_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && legal) begin
          off_d       = req_addr_i[1:0];
          be_d        = req_byte_en_i;
          be8_d       = be8_n;
          wd64_d      = wd64_n;
          wr_d        = req_wr_en_i;
          sgn_d       = req_signed_i;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_wr_en_i;
          mem_addr_d  = {req_addr_i[31:2], 2'b00};
          mem_be_d    = be8_n[3:0];
          mem_wdata_d = wd64_n[31:0];
          state_d     = S_ACC0;
        end
      end

      S_ACC0: begin
        if (mem_ack_i) begin
          lo_d  = mem_rdata_i;
          cnt_d = '0;
          if (|be8_q[7:4]) begin
            // Request stays up; only the address/lanes/data advance to the next word.
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = be8_q[7:4];
            mem_wdata_d = wd64_q[63:32];
            state_d     = S_ACC1;
          end else begin
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = '0;
            mem_be_d     = '0;
            mem_wdata_d  = '0;
            resp_valid_d = 1'b1;
            resp_rdata_d = wr_q ? 32'h0 : load_result({32'h0, mem_rdata_i}, off_q, be_q, sgn_q);
            state_d      = S_RESP;
          end
        end else if (timed_out) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_be_d     = '0;
          mem_wdata_d  = '0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          state_d      = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ACC1: begin
        if (mem_ack_i || timed_out) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_be_d     = '0;
          mem_wdata_d  = '0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
          if (mem_ack_i) begin
            resp_rdata_d = wr_q ? 32'h0 : load_result({mem_rdata_i, lo_q}, off_q, be_q, sgn_q);
          end else begin
            err_d = 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      be_q         <= '0;
      be8_q        <= '0;
      wd64_q       <= '0;
      wr_q         <= 1'b0;
      sgn_q        <= 1'b0;
      lo_q         <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      be_q         <= be_d;
      be8_q        <= be8_d;
      wd64_q       <= wd64_d;
      wr_q         <= wr_d;
      sgn_q        <= sgn_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-stepped memory responder and hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr_en;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        req_signed;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid),
    .req_wr_en_i   (req_wr_en),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_byte_en_i (req_byte_en),
    .req_signed_i  (req_signed),
    .stall_o       (stall_o),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-access observations
  logic [31:0] xa [2];
  logic [31:0] xwd [2];
  logic [3:0]  xbe [2];
  logic        xwe [2];
  int          xc0;
  int          nx;
  int          rc;
  int          stall_n;
  logic [31:0] rdat;
  logic        rerr;
  bit          got_resp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; cycle 0 is the request cycle.
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic sgn, input int waits,
                           input logic [31:0] rd0, input logic [31:0] rd1, input bit never_ack);
    int  wcnt;
    int  idx;
    bit  fresh;
    nx = 0; rc = -1; xc0 = -1; stall_n = 0; got_resp = 0;
    rdat = '0; rerr = 1'b0; wcnt = 0; fresh = 1;
    req_valid = 1'b1; req_wr_en = wr; req_addr = addr;
    req_wdata = wdata; req_byte_en = be; req_signed = sgn;
    #1;
    if (stall_o) stall_n++;
    for (int c = 1; c <= 40 && !got_resp; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      #1;
      if (stall_o) stall_n++;
      if (resp_valid_o) begin
        got_resp = 1;
        rc   = c;
        rdat = resp_rdata_o;
        rerr = err_o;
        check_val("req_low_at_resp", {31'b0, mem_req_o}, 32'h0);
      end else if (mem_req_o) begin
        idx = (nx < 2) ? nx : 1;
        if (fresh) begin
          xa[idx]  = mem_addr_o;
          xwd[idx] = mem_wdata_o;
          xbe[idx] = mem_be_o;
          xwe[idx] = mem_we_o;
          if (nx == 0) xc0 = c;
          fresh = 0;
          wcnt  = 0;
        end else begin
          check_val("stable_addr", mem_addr_o, xa[idx]);
          check_val("stable_wdata", mem_wdata_o, xwd[idx]);
        end
        if (!never_ack && wcnt == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = (nx == 0) ? rd0 : rd1;
          nx++;
          fresh = 1;
        end else begin
          wcnt++;
        end
      end
    end
    if (!got_resp) check_val("resp_never_seen", 32'h0, 32'h1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_val("resp_one_pulse", {31'b0, resp_valid_o}, 32'h0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = 1'b0; req_wr_en = 1'b0; req_addr = '0;
    req_wdata = '0; req_byte_en = '0; req_signed = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check_val("rst_mem_addr", mem_addr_o, 32'h0);
    check_val("rst_mem_wdata", mem_wdata_o, 32'h0);
    check_val("rst_mem_be", {28'b0, mem_be_o}, 32'h0);
    check_val("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
    check_val("rst_resp", {30'b0, resp_valid_o, err_o}, 32'h0);
    check_val("rst_rdata", resp_rdata_o, 32'h0);
    check_val("rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LW aligned, zero wait
    do_access(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 0, 32'hDEADBEEF, 32'h0, 0);
    check_val("lw_req_cycle", xc0, 32'd1);
    check_val("lw_addr", xa[0], 32'h100);
    check_val("lw_be", {28'b0, xbe[0]}, 32'hF);
    check_val("lw_we", {31'b0, xwe[0]}, 32'h0);
    check_val("lw_resp_cycle", rc, 32'd2);
    check_val("lw_rdata", rdat, 32'hDEADBEEF);
    check_val("lw_err", {31'b0, rerr}, 32'h0);
    check_val("lw_stall_cycles", stall_n, 32'd2);
    check_val("lw_xfers", nx, 32'd1);

    // LB / LBU at byte 3
    do_access(1'b0, 32'h203, 32'h0, 4'b0001, 1'b1, 0, 32'h80112233, 32'h0, 0);
    check_val("lb_addr", xa[0], 32'h200);
    check_val("lb_be", {28'b0, xbe[0]}, 32'h8);
    check_val("lb_rdata", rdat, 32'hFFFFFF80);
    do_access(1'b0, 32'h203, 32'h0, 4'b0001, 1'b0, 0, 32'h80112233, 32'h0, 0);
    check_val("lbu_rdata", rdat, 32'h00000080);

    // LH signed, upper half
    do_access(1'b0, 32'h102, 32'h0, 4'b0011, 1'b1, 1, 32'h80017777, 32'h0, 0);
    check_val("lh_be", {28'b0, xbe[0]}, 32'hC);
    check_val("lh_rdata", rdat, 32'hFFFF8001);
    check_val("lh_resp_cycle", rc, 32'd3);

    // SH at 0x302
    do_access(1'b1, 32'h302, 32'h0000ABCD, 4'b0011, 1'b0, 0, 32'h12345678, 32'h0, 0);
    check_val("sh_be", {28'b0, xbe[0]}, 32'hC);
    check_val("sh_wdata", xwd[0], 32'hABCD0000);
    check_val("sh_we", {31'b0, xwe[0]}, 32'h1);
    check_val("sh_xfers", nx, 32'd1);
    check_val("sh_rdata", rdat, 32'h0);

    // SW split at 0x401
    do_access(1'b1, 32'h401, 32'h11223344, 4'b1111, 1'b0, 0, 32'h0, 32'h0, 0);
    check_val("sw_a0", xa[0], 32'h400);
    check_val("sw_be0", {28'b0, xbe[0]}, 32'hE);
    check_val("sw_wd0", xwd[0], 32'h22334400);
    check_val("sw_a1", xa[1], 32'h404);
    check_val("sw_be1", {28'b0, xbe[1]}, 32'h1);
    check_val("sw_wd1", xwd[1], 32'h00000011);
    check_val("sw_we1", {31'b0, xwe[1]}, 32'h1);
    check_val("sw_resp_cycle", rc, 32'd3);
    check_val("sw_rdata", rdat, 32'h0);

    // LW split across the top of the address space
    do_access(1'b0, 32'hFFFFFFFE, 32'h0, 4'b1111, 1'b0, 0, 32'hAAAA0000, 32'h0000BBBB, 0);
    check_val("wrap_a0", xa[0], 32'hFFFFFFFC);
    check_val("wrap_a1", xa[1], 32'h00000000);
    check_val("wrap_be0", {28'b0, xbe[0]}, 32'hC);
    check_val("wrap_be1", {28'b0, xbe[1]}, 32'h3);
    check_val("wrap_rdata", rdat, 32'hBBBBAAAA);
    check_val("wrap_resp_cycle", rc, 32'd3);
    do_access(1'b0, 32'hFFFFFFFE, 32'h0, 4'b1111, 1'b0, 3, 32'hAAAA0000, 32'h0000BBBB, 0);
    check_val("wrap_wait_rdata", rdat, 32'hBBBBAAAA);
    check_val("wrap_wait_resp_cycle", rc, 32'd9);
    check_val("wrap_wait_stall", stall_n, 32'd9);

    // LH split across a word boundary, zero-extended
    do_access(1'b0, 32'h003, 32'h0, 4'b0011, 1'b0, 0, 32'hCD000000, 32'h000000AB, 0);
    check_val("lhs_be0", {28'b0, xbe[0]}, 32'h8);
    check_val("lhs_be1", {28'b0, xbe[1]}, 32'h1);
    check_val("lhs_rdata", rdat, 32'h0000ABCD);

    // Timeout with memory never acking
    do_access(1'b0, 32'h500, 32'h0, 4'b1111, 1'b0, 0, 32'h0, 32'h0, 1);
    check_val("tmo_resp_cycle", rc, 32'd6);
    check_val("tmo_err", {31'b0, rerr}, 32'h1);
    check_val("tmo_rdata", rdat, 32'h0);
    check_val("tmo_stall", stall_n, 32'd6);

    // Illegal byte enable: nothing happens
    req_valid = 1'b1; req_wr_en = 1'b0; req_addr = 32'h600; req_byte_en = 4'b0101;
    #1;
    check_val("illegal_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    #1;
    check_val("illegal_req", {31'b0, mem_req_o}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_val("illegal_resp", {31'b0, resp_valid_o}, 32'h0);

    // Reset during ACC0
    req_valid = 1'b1; req_wr_en = 1'b1; req_addr = 32'h700; req_wdata = 32'h55;
    req_byte_en = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_val("rstmid_req_before", {31'b0, mem_req_o}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_val("rstmid_req_after", {31'b0, mem_req_o}, 32'h0);
    check_val("rstmid_stall", {31'b0, stall_o}, 32'h0);
    rst_n = 1'b1;
    seen = resp_valid_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      seen = seen | resp_valid_o | mem_req_o;
    end
    check_val("rstmid_no_resp", {31'b0, seen}, 32'h0);

    // Recovery after reset
    do_access(1'b0, 32'h104, 32'h0, 4'b1111, 1'b0, 2, 32'h01020304, 32'h0, 0);
    check_val("recover_rdata", rdat, 32'h01020304);
    check_val("recover_resp_cycle", rc, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
